// File: rtl/ahbl_gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO port: register offsets, bus encodings,
// data-phase FSM states and byte-lane helpers.
package ahbl_gpio_pkg;

  localparam logic [7:0] OFS_DATA_IN  = 8'h00;
  localparam logic [7:0] OFS_DATA_OUT = 8'h04;
  localparam logic [7:0] OFS_DIR      = 8'h08;
  localparam logic [7:0] OFS_SET      = 8'h0C;
  localparam logic [7:0] OFS_CLR      = 8'h10;
  localparam logic [7:0] OFS_IM       = 8'h14;
  localparam logic [7:0] OFS_RIS      = 8'h18;
  localparam logic [7:0] OFS_MIS      = 8'h1C;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } gpio_state_e;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr;
      HSIZE_HALF: lane_mask = addr[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] mask);
    for (int unsigned i = 0; i < 4; i++) begin
      lane_bits[8*i +: 8] = {8{mask[i]}};
    end
  endfunction

endpackage

// File: rtl/ahbl_gpio_port_if.sv
// AHB-Lite slave-side signal bundle between the GPIO bus splitter and one GPIO port.
interface ahbl_gpio_port_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahbl_gpio_sync.sv
// WIDTH-bit two-flop synchronizer for pad inputs; optionally keeps the previous
// synchronized sample so callers can detect edges.
module ahbl_gpio_sync #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          EDGE_DET = 1'b0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] prev_out
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

  if (EDGE_DET) begin : g_prev
    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) prev_out <= '0;
      else          prev_out <= sync_out;
    end
  end else begin : g_no_prev
    assign prev_out = '0;
  end

endmodule

// File: rtl/ahbl_gpio_port.sv
// AHB-Lite GPIO port responder with DATA_IN/DATA_OUT/DIR/SET/CLR and fixed wait states.
// Define AHBL_GPIO_PORT_IRQ_EN to add IM/RIS/MIS rising-edge interrupt registers and irq.
module ahbl_gpio_port
  import ahbl_gpio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      WAIT_STATES = 0,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahbl_gpio_port_if.slave  ahb,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

`ifdef AHBL_GPIO_PORT_IRQ_EN
  localparam bit EDGE_DET = 1'b1;
`else
  localparam bit EDGE_DET = 1'b0;
`endif

  gpio_state_e      state, state_n;
  logic [2:0]       wcnt, wcnt_n;
  logic [7:0]       ofs_q;
  logic             wr_q;
  logic [3:0]       mask_q;
  logic             accept;
  logic             commit;
  logic [31:0]      lanes;
  logic [31:0]      wsel;
  logic [31:0]      rdata;
  logic [WIDTH-1:0] data_out, dir;
  logic [WIDTH-1:0] sync_in, sync_prev;
  logic             unused_bus;

  ahbl_gpio_sync #(.WIDTH(WIDTH), .EDGE_DET(EDGE_DET)) u_sync (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .async_in(gpio_in),
    .sync_out(sync_in),
    .prev_out(sync_prev)
  );

  assign accept = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY & (state != ST_WAIT);

  // Offset is kept word-aligned; the low address bits only select byte lanes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= ST_IDLE;
      wcnt   <= '0;
      ofs_q  <= '0;
      wr_q   <= 1'b0;
      mask_q <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (accept) begin
        ofs_q  <= {ahb.HADDR[7:2], 2'b00};
        wr_q   <= ahb.HWRITE;
        mask_q <= lane_mask(ahb.HSIZE, ahb.HADDR[1:0]);
      end
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    case (state)
      ST_WAIT: begin
        if (wcnt == '0) state_n = ST_DONE;
        else            wcnt_n  = wcnt - 3'd1;
      end
      default: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_WAIT;
            wcnt_n  = 3'(WAIT_STATES - 1);
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
    endcase
  end

  assign ahb.HREADYOUT = (state != ST_WAIT);

  assign commit = (state == ST_DONE) && wr_q;
  assign lanes  = lane_bits(mask_q);
  assign wsel   = ahb.HWDATA & lanes;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_out <= OUT_RESET;
      dir      <= '0;
    end else if (commit) begin
      case (ofs_q)
        OFS_DATA_OUT: data_out <= WIDTH'((32'(data_out) & ~lanes) | wsel);
        OFS_DIR:      dir      <= WIDTH'((32'(dir) & ~lanes) | wsel);
        OFS_SET:      data_out <= data_out | WIDTH'(wsel);
        OFS_CLR:      data_out <= data_out & ~WIDTH'(wsel);
        default:      ;
      endcase
    end
  end

  assign gpio_out = data_out;
  assign gpio_oe  = dir;

`ifdef AHBL_GPIO_PORT_IRQ_EN
  logic [WIDTH-1:0] im, ris, rise;

  assign rise = sync_in & ~sync_prev;

  // A freshly detected edge is OR-ed in after the W1C so it is never lost.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      im  <= '0;
      ris <= '0;
      irq <= 1'b0;
    end else begin
      if (commit && ofs_q == OFS_IM) im <= WIDTH'((32'(im) & ~lanes) | wsel);
      if (commit && ofs_q == OFS_RIS) ris <= (ris & ~WIDTH'(wsel)) | rise;
      else                            ris <= ris | rise;
      irq <= |(ris & im);
    end
  end

  assign unused_bus = ^{ahb.HADDR[31:8], ahb.HTRANS[0]};
`else
  assign irq        = 1'b0;
  assign unused_bus = ^{ahb.HADDR[31:8], ahb.HTRANS[0], sync_prev};
`endif

  always_comb begin
    rdata = '0;
    if (state == ST_DONE && !wr_q) begin
      case (ofs_q)
        OFS_DATA_IN:  rdata = 32'(sync_in);
        OFS_DATA_OUT: rdata = 32'(data_out);
        OFS_DIR:      rdata = 32'(dir);
`ifdef AHBL_GPIO_PORT_IRQ_EN
        OFS_IM:       rdata = 32'(im);
        OFS_RIS:      rdata = 32'(ris);
        OFS_MIS:      rdata = 32'(ris & im);
`endif
        default:      rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA = rdata;

endmodule

// File: doc/ahbl_gpio_port.md
Name: ahbl_gpio_port

Overview:
- AHB-Lite responder for one GPIO port; sits behind the GPIO bus splitter on one of its A/B/C select lines.
- Drives HREADYOUT/HRDATA back to the splitter.
- Provides memory-mapped output data, direction and set/clear registers, plus a synchronized input read-back.
- Inserts a configurable number of wait states per transfer so splitter HREADY muxing is exercised.

Parameters:
- WIDTH, 16, number of GPIO pins (1..32).
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every data phase (0..7).
- OUT_RESET, 0, reset value of DATA_OUT (WIDTH bits).

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from splitter.
- HADDR  in  32  address; only HADDR[7:0] decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-level ready from splitter.
- HREADYOUT  out  1  this slave's ready.
- HRDATA  out  32  read data.
- gpio_in  in  WIDTH  asynchronous pad inputs.
- gpio_out  out  WIDTH  pad output values.
- gpio_oe  out  WIDTH  pad output enables, 1=drive.
- irq  out  1  interrupt; present only with the feature enabled, otherwise tied 0.

Behaviour:
- Clocking: one clock, HCLK; HRESETn asynchronous active-low.
- Reset values: HREADYOUT=1, HRDATA=0, gpio_out=OUT_RESET, gpio_oe=0, irq=0; sync flops and IRQ registers cleared.
- Register map, offset = HADDR[7:0]:
  - 0x00 DATA_IN, RO: 2-flop-synchronized gpio_in.
  - 0x04 DATA_OUT, RW.
  - 0x08 DIR, RW.
  - 0x0C SET, WO: bits written 1 set DATA_OUT.
  - 0x10 CLR, WO: bits written 1 clear DATA_OUT.
  - Bits above WIDTH read 0; writes to them are ignored.
- Unmapped offsets and reads of WO registers return 0; writes to unmapped offsets are ignored. No error response.
- Address phase accepted when HSEL & HTRANS[1] & HREADY. At acceptance, latch offset, HWRITE and a 4-bit byte-lane mask from HSIZE/HADDR[1:0] (word = 1111, half = 0011/1100, byte = one-hot).
- FSM states:
  - IDLE: no data phase pending; HREADYOUT=1.
  - WAIT: counting WAIT_STATES cycles; HREADYOUT=0.
  - DONE: final data-phase cycle; HREADYOUT=1.
- FSM transitions:
  - Accept with WAIT_STATES=0 -> DONE.
  - Accept with WAIT_STATES>0 -> WAIT; WAIT -> DONE after WAIT_STATES cycles.
  - DONE with new accept -> DONE or WAIT as above (back-to-back, no bubble).
  - DONE without accept -> IDLE.
- Write commit: on the clock edge ending DONE, using HWDATA and the lane mask. SET/CLR modify only masked lanes.
- Read data: HRDATA is valid in DONE, decoded combinationally from the latched offset. Outside DONE, HRDATA=0.
- Write-then-read of the same register back-to-back returns the newly written value.
- gpio_in change becomes visible in DATA_IN reads 2 HCLK edges later.
- HSEL deasserted or HTRANS IDLE/BUSY while HREADY=1: no access; FSM goes to IDLE after any pending DONE.
- Reset asserted mid-transfer: immediate return to IDLE and reset values; any pending write is dropped.
- gpio_out = DATA_OUT and gpio_oe = DIR, both driven directly from registers; no combinational path from the bus.

Optional Feature:
- Macro: AHBL_GPIO_PORT_IRQ_EN.
- Enabled: adds three registers.
  - 0x14 IM, RW mask.
  - 0x18 RIS, W1C: bit set on a rising edge of the synchronized input.
  - 0x1C MIS, RO = RIS & IM.
  - irq = |MIS, registered.
  - Edge detection and a W1C of the same bit in the same cycle: the set wins.
- Disabled: offsets 0x14-0x1C behave as unmapped, irq is tied 0, and the edge-detect flops are absent.

Decomposition:
- Shared package ahbl_gpio_pkg: register offset constants, HTRANS encodings (IDLE=0, NONSEQ=2), HSIZE encodings, FSM state typedef.
- One natural sub-module: ahbl_gpio_sync, a parameterized WIDTH-bit 2-flop synchronizer that also exposes the previous-sample vector for edge detection.

Test Plan:
- Reset and defaults: reset, then read 0x04 and 0x08 -> 0x0 each; gpio_oe=0; HREADYOUT=1.
- Wait states: WAIT_STATES=2, word write 0x04 = 0x0000A5A5 -> HREADYOUT low exactly 2 cycles, then gpio_out=0xA5A5; read back 0xA5A5.
- Set/clear and byte lanes: after DATA_OUT=0xA5A5, write SET 0x0F00, then CLR 0x0005 -> DATA_OUT=0xAFA0. Byte write of 0xFF to 0x05 -> DATA_OUT=0xFFA0.
- Input sync: gpio_in=0x1234 applied -> DATA_IN read issued 1 cycle later returns the old value; read issued 3 cycles later returns 0x1234.
- Back-to-back and unmapped: write DIR=0x00FF immediately followed by read DIR -> 0x00FF with no idle cycle between. Read 0x40 -> 0x0; write 0x40 changes nothing.
- IRQ (AHBL_GPIO_PORT_IRQ_EN): IM=0x1, gpio_in[0] rises -> irq=1 within 4 cycles. W1C of RIS with 0x1 -> irq=0. Edge coincident with the clear -> RIS[0] stays 1.
